usb_receiver_drainer: RTL and testbench
=======================================

// Module: usb_receiver_drainer
// PURPOSE
//  Receive side of the FT245-style USB FIFO link. Waits for RXF_N, strobes RD_N, samples
//  D_USBTRANS and writes each byte into the USB buffer RAM from WADDR_START upward.
//  Stops after PKT_LEN bytes or a receive timeout. Sits between the USB transceiver pins
//  and the receive-side buffer; the control sequencer arms it with START and reads COMPLT.
// PARAMETERS
//  PKT_LEN      128    bytes per packet, 1..256
//  RD_LOW_CYC   3      CLK cycles RD_N is held low per byte, >=2
//  RD_HIGH_CYC  3      CLK cycles RD_N is held high after each byte, >=3 (covers RXF_N sync lag)
//  TIMEOUT_CYC  65535  idle cycles in WAIT before abort, >=1; 16-bit counter
// PORTS
//  CLK            in   1  system clock; all logic on posedge
//  RST_N          in   1  asynchronous active-low reset
//  START          in   1  1-cycle arm pulse; ignored unless IDLE
//  WADDR_START    in   8  first buffer write address, latched on START
//  RXF_N          in   1  transceiver: low = byte available (asynchronous)
//  RD_N           out  1  transceiver read strobe, active low
//  D_USBTRANS     in   8  transceiver data bus
//  WE_USBBUFF     out  1  buffer write enable, 1-cycle pulse per byte
//  WADDR_USBBUFF  out  8  buffer write address
//  D_USBBUFF      out  8  buffer write data
//  BYTE_CNT       out  9  bytes written in current/last packet
//  BUSY           out  1  high from START accept until DONE
//  COMPLT         out  1  sticky packet-finished flag, cleared by next accepted START
//  TMO            out  1  sticky: packet ended by timeout
//  SEQ_ERR        out  1  sticky: packet ended by sequence error (0 without macro)
// BEHAVIOUR
//  - Reset values: RD_N=1, WE_USBBUFF=0, WADDR_USBBUFF=0, D_USBBUFF=0, BYTE_CNT=0, BUSY=0,
//    COMPLT=0, TMO=0, SEQ_ERR=0; state=IDLE; sync flops=1. Reset mid-read forces RD_N=1 at once.
//  - RXF_N passes a 2-flop synchroniser (reset to 1); all decisions use the synced value rxf_s.
//  - FSM IDLE->WAIT->STROBE->RECOV->(WAIT|DONE)->IDLE.
//  - IDLE: on START, latch WADDR_START into WADDR_USBBUFF; clear BYTE_CNT, COMPLT, TMO, SEQ_ERR
//    and the timeout counter; set BUSY=1; go to WAIT.
//  - WAIT: if rxf_s=0, drive RD_N=0, clear the phase counter, clear the timeout counter, go to
//    STROBE. Otherwise the timeout counter increments. When it reaches TIMEOUT_CYC, set TMO=1
//    and go to DONE.
//  - STROBE: RD_N stays low for exactly RD_LOW_CYC cycles. On the edge that ends this phase:
//    D_USBBUFF<=D_USBTRANS, RD_N<=1, WE_USBBUFF<=1, go to RECOV.
//  - RECOV: WE_USBBUFF is high for the first RECOV cycle only. The buffer captures
//    WADDR_USBBUFF/D_USBBUFF in that cycle. On the following edge, WADDR_USBBUFF+=1 and
//    BYTE_CNT+=1. After RD_HIGH_CYC cycles: if BYTE_CNT==PKT_LEN go to DONE, else go to WAIT.
//  - DONE (1 cycle): BUSY<=0, COMPLT<=1; go to IDLE. COMPLT, TMO and SEQ_ERR hold until the next
//    accepted START.
//  - WADDR_USBBUFF wraps 8'hFF->8'h00 modulo 256. BYTE_CNT never exceeds PKT_LEN.
//  - Throughput: a byte already present takes 1+RD_LOW_CYC+RD_HIGH_CYC cycles (7 at defaults).
//    RD_N falls 3 edges after RXF_N is first sampled low (2 sync + 1 WAIT).
//  - START while BUSY is ignored. RXF_N toggling during STROBE/RECOV is ignored.
//  - A TMO abort leaves BYTE_CNT at the number of bytes actually written.
// CONFIGURATION
//  USB_RX_SEQ_CHECK_EN defined: bit0 of received bytes must alternate 0,1,0,... starting at 0
//    for each packet; the expected value resets on START. This matches the transmit-side pumper
//    tagging. On the STROBE-end edge a mismatch suppresses WE_USBBUFF and the increments, sets
//    SEQ_ERR=1, raises RD_N and goes to DONE.
//  Undefined: no check, the byte is stored as received, SEQ_ERR is tied to 0.
// TESTING
//  1. Reset mid-STROBE (RST_N low while RD_N=0) -> RD_N=1 at once; all outputs at reset values;
//     state IDLE.
//  2. START, WADDR_START=8'h10, RXF_N held low, bytes 8'h00,8'h01,..,8'h7F
//     -> 128 WE pulses at 8'h10..8'h8F with matching data, 7 cycles apart;
//     COMPLT=1, BYTE_CNT=128, TMO=0.
//  3. WADDR_START=8'hF0, PKT_LEN=32 -> writes 8'hF0..8'hFF then 8'h00..8'h0F;
//     final WADDR_USBBUFF=8'h10.
//  4. TIMEOUT_CYC=100, RXF_N high after 5 bytes -> TMO=1, COMPLT=1, BYTE_CNT=5, BUSY=0;
//     RD_N stays high throughout the wait.
//  5. START pulsed again while BUSY -> no change to WADDR_USBBUFF or BYTE_CNT; packet completes
//     normally.
//  6. (USB_RX_SEQ_CHECK_EN) bytes 8'h00,8'h01,8'h02,8'h02 -> 3 writes; 4th byte not written;
//     SEQ_ERR=1, COMPLT=1, BYTE_CNT=3.
//     Without the macro, same stimulus -> 4 writes, SEQ_ERR=0.

Source files
------------

// File: rtl/usb_receiver_drainer.sv
// usb_receiver_drainer: FT245-style USB FIFO receive side, drains RXF_N/RD_N bytes into the USB buffer RAM
// Ports: CLK, RST_N (async, active low); START/WADDR_START arm a packet; RXF_N/RD_N/D_USBTRANS
// talk to the transceiver; WE_USBBUFF/WADDR_USBBUFF/D_USBBUFF write the buffer; BYTE_CNT, BUSY,
// COMPLT, TMO, SEQ_ERR report status. Define USB_RX_SEQ_CHECK_EN to enable the bit0 alternation check.
module usb_receiver_drainer #(
  parameter int PKT_LEN     = 128,
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [7:0] WADDR_START,
  input  logic       RXF_N,
  output logic       RD_N,
  input  logic [7:0] D_USBTRANS,
  output logic       WE_USBBUFF,
  output logic [7:0] WADDR_USBBUFF,
  output logic [7:0] D_USBBUFF,
  output logic [8:0] BYTE_CNT,
  output logic       BUSY,
  output logic       COMPLT,
  output logic       TMO,
  output logic       SEQ_ERR
);
  typedef enum logic [2:0] {IDLE, WAIT, STROBE, RECOV, DONE} state_t;
  state_t state, state_nx;
  logic rxf_m, rxf_s;
  logic [15:0] ph, tmo_cnt;
  logic start, lo_end, hi_end, tmo_hit, seq_bad;
  assign start   = state == IDLE && START;
  assign lo_end  = state == STROBE && ph == 16'(RD_LOW_CYC - 1);
  assign hi_end  = ph == 16'(RD_HIGH_CYC - 1);
  assign tmo_hit = tmo_cnt == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = START ? WAIT : IDLE;
      WAIT:    state_nx = !rxf_s ? STROBE : tmo_hit ? DONE : WAIT;
      STROBE:  state_nx = !lo_end ? STROBE : seq_bad ? DONE : RECOV;
      RECOV:   state_nx = !hi_end ? RECOV : BYTE_CNT == 9'(PKT_LEN) ? DONE : WAIT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // RD_N is a pure decode of the next state so it is low exactly while in STROBE
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      rxf_m         <= 1'b1;
      rxf_s         <= 1'b1;
      ph            <= '0;
      tmo_cnt       <= '0;
      RD_N          <= 1'b1;
      WE_USBBUFF    <= 1'b0;
      WADDR_USBBUFF <= '0;
      D_USBBUFF     <= '0;
      BYTE_CNT      <= '0;
      BUSY          <= 1'b0;
      COMPLT        <= 1'b0;
      TMO           <= 1'b0;
    end else begin
      rxf_m      <= RXF_N;
      rxf_s      <= rxf_m;
      ph         <= state_nx != state ? '0 : ph + 16'd1;
      tmo_cnt    <= state == WAIT && rxf_s ? tmo_cnt + 16'd1 : '0;
      RD_N       <= state_nx != STROBE;
      WE_USBBUFF <= lo_end && !seq_bad;
      if (lo_end) D_USBBUFF <= D_USBTRANS;
      if (start) begin
        WADDR_USBBUFF <= WADDR_START;
        BYTE_CNT      <= '0;
        BUSY          <= 1'b1;
        COMPLT        <= 1'b0;
        TMO           <= 1'b0;
      end
      if (WE_USBBUFF) begin
        WADDR_USBBUFF <= WADDR_USBBUFF + 8'd1;
        BYTE_CNT      <= BYTE_CNT + 9'd1;
      end
      if (state == WAIT && rxf_s && tmo_hit) TMO <= 1'b1;
      if (state == DONE) begin
        BUSY   <= 1'b0;
        COMPLT <= 1'b1;
      end
    end
`ifdef USB_RX_SEQ_CHECK_EN
  logic exp_bit;
  assign seq_bad = D_USBTRANS[0] != exp_bit;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      exp_bit <= 1'b0;
      SEQ_ERR <= 1'b0;
    end else if (start) begin
      exp_bit <= 1'b0;
      SEQ_ERR <= 1'b0;
    end else if (lo_end) begin
      if (seq_bad) SEQ_ERR <= 1'b1;
      else exp_bit <= ~exp_bit;
    end
`else
  assign seq_bad = 1'b0;
  assign SEQ_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_usb_receiver_drainer.sv
// tb_usb_receiver_drainer: directed bench with a transceiver model and a write scoreboard
module tb_usb_receiver_drainer;
  localparam int PKT = 128;
  localparam int TMO_C = 100;
  logic CLK = 1'b0, RST_N = 1'b1, START = 1'b0, RXF_N = 1'b1;
  logic [7:0] WADDR_START = 8'h00, D_USBTRANS = 8'h00;
  logic RD_N, WE_USBBUFF, BUSY, COMPLT, TMO, SEQ_ERR;
  logic [7:0] WADDR_USBBUFF, D_USBBUFF;
  logic [8:0] BYTE_CNT;
  int checks = 0, failures = 0;
  int cyc = 0, wr_seen = 0, last_we = -100;
  bit chk_en = 0, busy_prev = 0;
  logic [7:0] tx_q[$], exp_q[$], pkt[$];
  logic [7:0] exp_start = 8'h00;
  logic [8:0] e;
  always #5 CLK = ~CLK;
  usb_receiver_drainer #(.PKT_LEN(PKT), .TIMEOUT_CYC(TMO_C)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .WADDR_START(WADDR_START), .RXF_N(RXF_N),
    .RD_N(RD_N), .D_USBTRANS(D_USBTRANS), .WE_USBBUFF(WE_USBBUFF), .WADDR_USBBUFF(WADDR_USBBUFF),
    .D_USBBUFF(D_USBBUFF), .BYTE_CNT(BYTE_CNT), .BUSY(BUSY), .COMPLT(COMPLT), .TMO(TMO), .SEQ_ERR(SEQ_ERR)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic upd();
    RXF_N = tx_q.size() == 0;
    D_USBTRANS = tx_q.size() > 0 ? tx_q[0] : 8'h00;
  endtask
  always @(posedge RD_N) begin
    if (tx_q.size() > 0) void'(tx_q.pop_front());
    upd();
  end
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (chk_en) begin
    if (BUSY && !busy_prev) wr_seen = 0;
    busy_prev = BUSY;
    check("byte_cnt_track", BYTE_CNT, wr_seen);
    if (BUSY) check("waddr_track", WADDR_USBBUFF, 8'(exp_start + wr_seen));
    check("rd_n_idle", RD_N | BUSY, 1);
    if (WE_USBBUFF) begin
      e = 9'h100;
      if (exp_q.size() > 0) e = {1'b0, exp_q.pop_front()};
      check("we_data", {1'b0, D_USBBUFF}, e);
      if (wr_seen > 0) check("we_gap", cyc - last_we, 7);
      last_we = cyc;
      wr_seen++;
    end
  end
  task automatic chk_rst(input string t);
    check({t, "_rd_n"}, RD_N, 1);
    check({t, "_we"}, WE_USBBUFF, 0);
    check({t, "_waddr"}, WADDR_USBBUFF, 0);
    check({t, "_data"}, D_USBBUFF, 0);
    check({t, "_byte_cnt"}, BYTE_CNT, 0);
    check({t, "_busy"}, BUSY, 0);
    check({t, "_complt"}, COMPLT, 0);
    check({t, "_tmo"}, TMO, 0);
    check({t, "_seq_err"}, SEQ_ERR, 0);
  endtask
  task automatic run(input logic [7:0] sa, input bit dbl, input int lc, input int la, input bit lt, input bit ls);
    int n, k, s, rd_low;
    bit se, te;
    n = 0; se = 0; rd_low = 0;
    exp_q.delete();
    for (int i = 0; i < pkt.size() && n < PKT && !se; i++) begin
`ifdef USB_RX_SEQ_CHECK_EN
      se = pkt[i][0] != 1'(i % 2);
`endif
      if (!se) begin
        exp_q.push_back(pkt[i]);
        n++;
      end
    end
    te = !se && n < PKT;
    tx_q = pkt;
    upd();
    repeat (4) @(negedge CLK);
    exp_start = sa;
    WADDR_START = sa;
    START = 1'b1;
    s = cyc;
    @(negedge CLK);
    START = 1'b0;
    WADDR_START = 8'h00;
    k = 1;
    while (!WE_USBBUFF && k < 30) begin
      @(negedge CLK);
      k++;
    end
    check("first_we_latency", cyc - s, 5);
    if (dbl) begin
      repeat (20) @(negedge CLK);
      WADDR_START = 8'h99;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      WADDR_START = 8'h00;
    end
    k = 0;
    while (BUSY && k < 3000) begin
      @(negedge CLK);
      k++;
      if (te && wr_seen == n && !RD_N) rd_low++;
    end
    check("busy_done", BUSY, 0);
    check("complt", COMPLT, 1);
    check("byte_cnt_model", BYTE_CNT, n);
    check("tmo_model", TMO, te);
    check("seq_err_model", SEQ_ERR, se);
    check("waddr_final_model", WADDR_USBBUFF, 8'(sa + n));
    check("writes_missing", exp_q.size(), 0);
    check("byte_cnt_lit", BYTE_CNT, lc);
    check("waddr_final_lit", WADDR_USBBUFF, la);
    check("tmo_lit", TMO, lt);
    check("seq_err_lit", SEQ_ERR, ls);
    if (te) begin
      check("rd_n_low_in_wait", rd_low, 0);
      check("tmo_latency", cyc - last_we, 104);
    end
  endtask
  initial begin
    int k;
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk_rst("por");
    RST_N = 1'b1;
    pkt = '{8'h00, 8'h01, 8'h02};
    tx_q = pkt;
    upd();
    repeat (4) @(negedge CLK);
    WADDR_START = 8'h55;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    k = 0;
    while (RD_N && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check("rd_n_low_before_reset", RD_N, 0);
    #2 RST_N = 1'b0;
    #1 chk_rst("mid_strobe");
    tx_q.delete();
    upd();
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk_en = 1;
    pkt.delete();
    for (int i = 0; i < 128; i++) pkt.push_back(8'(i));
    run(8'h10, 0, 128, 8'h90, 0, 0);
    pkt.delete();
    for (int i = 0; i < 128; i++) pkt.push_back(8'(i) ^ 8'hA4);
    run(8'hF0, 0, 128, 8'h70, 0, 0);
    pkt = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    run(8'h20, 0, 5, 8'h25, 1, 0);
    pkt.delete();
    for (int i = 0; i < 128; i++) pkt.push_back(8'(i) ^ 8'h5A);
    run(8'h40, 1, 128, 8'hC0, 0, 0);
    pkt = '{8'h00, 8'h01, 8'h02, 8'h02};
`ifdef USB_RX_SEQ_CHECK_EN
    run(8'h30, 0, 3, 8'h33, 0, 1);
`else
    run(8'h30, 0, 4, 8'h34, 1, 0);
`endif
    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
